// File: rtl/biriscv_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : biriscv_decode_pkg
//  Description : Shared definitions for the multi-lane decode queue:
//                class-flag bit positions, the decoded-entry record and the
//                RV32IM opcode/funct constants used by the lane classifier.
//  Ports       : (package - none)
//  Revision    : 1.0 - initial release
// ============================================================================
package biriscv_decode_pkg;

  // Class vector layout: {invalid, csr, div, mul, branch, lsu, exec, rd_valid}
  localparam int CLASS_W      = 8;
  localparam int CLS_RD_VALID = 0;
  localparam int CLS_EXEC     = 1;
  localparam int CLS_LSU      = 2;
  localparam int CLS_BRANCH   = 3;
  localparam int CLS_MUL      = 4;
  localparam int CLS_DIV      = 5;
  localparam int CLS_CSR      = 6;
  localparam int CLS_INVALID  = 7;

  // Major opcodes (bits 6:0)
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct7 values
  localparam logic [6:0] F7_BASE       = 7'b0000000;
  localparam logic [6:0] F7_ALT        = 7'b0100000;
  localparam logic [6:0] F7_MULDIV     = 7'b0000001;
  localparam logic [6:0] F7_SFENCE_VMA = 7'b0001001;

  // Fully-specified SYSTEM encodings
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] INST_WFI    = 32'h1050_0073;

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        opcode;
    logic [CLASS_W-1:0] cls;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
  } decode_entry_t;

endpackage : biriscv_decode_pkg
`default_nettype wire

// File: rtl/biriscv_decode_lane.sv
`default_nettype none
// ============================================================================
//  Module      : biriscv_decode_lane
//  Description : Purely combinational classifier for one fetched opcode.
//                Produces the 8-bit class vector and raw register fields.
//  Ports       : opcode_i         - 32-bit instruction word
//                fault_i          - fetch fault; forces an invalid entry
//                enable_muldiv_i  - runtime M-extension enable
//                class_o          - {invalid,csr,div,mul,branch,lsu,exec,rd_valid}
//                rd_o/rs1_o/rs2_o - register index fields of the word
//  Revision    : 1.0 - initial release
// ============================================================================
module biriscv_decode_lane
  import biriscv_decode_pkg::*;
#(
  parameter int SUPPORT_MULDIV = 1
) (
  input  logic [31:0]        opcode_i,
  input  logic               fault_i,
  input  logic               enable_muldiv_i,
  output logic [CLASS_W-1:0] class_o,
  output logic [4:0]         rd_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_muldiv_en;

  assign w_opc       = opcode_i[6:0];
  assign w_f3        = opcode_i[14:12];
  assign w_f7        = opcode_i[31:25];
  assign w_muldiv_en = (SUPPORT_MULDIV != 0) && enable_muldiv_i;

  assign rd_o  = opcode_i[11:7];
  assign rs1_o = opcode_i[19:15];
  assign rs2_o = opcode_i[24:20];

  logic w_known;
  logic w_exec;
  logic w_lsu;
  logic w_branch;
  logic w_mul;
  logic w_div;
  logic w_csr;
  logic w_writes_rd;

  always_comb begin
    w_known     = 1'b0;
    w_exec      = 1'b0;
    w_lsu       = 1'b0;
    w_branch    = 1'b0;
    w_mul       = 1'b0;
    w_div       = 1'b0;
    w_csr       = 1'b0;
    w_writes_rd = 1'b0;

    case (w_opc)
      OPC_OP: begin
        // funct7=0100000 is only legal for SUB and SRA
        if ((w_f7 == F7_BASE) ||
            ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))) begin
          w_known     = 1'b1;
          w_exec      = 1'b1;
          w_writes_rd = 1'b1;
        end else if ((w_f7 == F7_MULDIV) && w_muldiv_en) begin
          w_known     = 1'b1;
          w_writes_rd = 1'b1;
          // funct3[2] separates DIV/DIVU/REM/REMU from the MUL family
          if (w_f3[2]) w_div = 1'b1;
          else         w_mul = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // shift-immediates carry a funct7 in imm[11:5]
        case (w_f3)
          3'b001:  w_known = (w_f7 == F7_BASE);
          3'b101:  w_known = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          default: w_known = 1'b1;
        endcase
        w_exec      = w_known;
        w_writes_rd = w_known;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_known     = 1'b1;
        w_exec      = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_JAL: begin
        w_known     = 1'b1;
        w_branch    = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_JALR: begin
        w_known     = (w_f3 == 3'b000);
        w_branch    = w_known;
        w_writes_rd = w_known;
      end
      OPC_BRANCH: begin
        w_known  = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_branch = w_known;
      end
      OPC_LOAD: begin
        w_known     = (w_f3 != 3'b011) && (w_f3 != 3'b111);
        w_lsu       = w_known;
        w_writes_rd = w_known;
      end
      OPC_STORE: begin
        w_known = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
        w_lsu   = w_known;
      end
      OPC_MISC_MEM: begin
        // FENCE and FENCE.I
        w_known = (w_f3 == 3'b000) || (w_f3 == 3'b001);
        w_csr   = w_known;
      end
      OPC_SYSTEM: begin
        if (w_f3 == 3'b000) begin
          w_known = (opcode_i == INST_ECALL) || (opcode_i == INST_EBREAK) ||
                    (opcode_i == INST_MRET)  || (opcode_i == INST_WFI)    ||
                    ((w_f7 == F7_SFENCE_VMA) && (opcode_i[11:7] == 5'd0));
          w_csr   = w_known;
        end else if (w_f3 != 3'b100) begin
          w_known     = 1'b1;
          w_csr       = 1'b1;
          w_writes_rd = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    class_o = '0;
    if (fault_i || !w_known) begin
      class_o[CLS_INVALID] = 1'b1;
      class_o[CLS_CSR]     = 1'b1;
    end else begin
      class_o[CLS_EXEC]     = w_exec;
      class_o[CLS_LSU]      = w_lsu;
      class_o[CLS_BRANCH]   = w_branch;
      class_o[CLS_MUL]      = w_mul;
      class_o[CLS_DIV]      = w_div;
      class_o[CLS_CSR]      = w_csr;
      class_o[CLS_RD_VALID] = w_writes_rd && (opcode_i[11:7] != 5'd0);
    end
  end

endmodule : biriscv_decode_lane
`default_nettype wire

// File: rtl/biriscv_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : biriscv_decode_queue
//  Description : Registered in-order decode buffer between fetch and issue.
//                Classifies up to LANES instructions per cycle, compacts the
//                valid ones into a DEPTH-entry circular queue and presents the
//                oldest LANES entries to issue.
//  Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//                in_valid_i/pc/opcode/fault - fetch bundle (holes allowed)
//                in_accept_o         - bundle taken this cycle
//                enable_muldiv_i     - runtime M-extension enable
//                flush_i             - drop all queued and incoming entries
//                out_valid_o         - thermometer of valid head lanes
//                out_pc/opcode/class/rd/rs1/rs2_o - head entries (0 when invalid)
//                out_pop_i           - head entries consumed this cycle
//                level_o             - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module biriscv_decode_queue
  import biriscv_decode_pkg::*;
#(
  parameter int LANES          = 2,
  parameter int DEPTH          = 8,
  parameter int SUPPORT_MULDIV = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [LANES-1:0]             in_valid_i,
  input  logic [LANES*32-1:0]          in_pc_i,
  input  logic [LANES*32-1:0]          in_opcode_i,
  input  logic [LANES-1:0]             in_fault_i,
  output logic                         in_accept_o,
  input  logic                         enable_muldiv_i,
  input  logic                         flush_i,
  output logic [LANES-1:0]             out_valid_o,
  output logic [LANES*32-1:0]          out_pc_o,
  output logic [LANES*32-1:0]          out_opcode_o,
  output logic [LANES*CLASS_W-1:0]     out_class_o,
  output logic [LANES*5-1:0]           out_rd_o,
  output logic [LANES*5-1:0]           out_rs1_o,
  output logic [LANES*5-1:0]           out_rs2_o,
  input  logic [$clog2(LANES+1)-1:0]   out_pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(LANES+1);

  // --------------------------------------------------------------------------
  // Per-lane classification
  // --------------------------------------------------------------------------
  decode_entry_t w_lane_entry [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [CLASS_W-1:0] w_cls;
    logic [4:0]         w_rd;
    logic [4:0]         w_rs1;
    logic [4:0]         w_rs2;

    biriscv_decode_lane #(
      .SUPPORT_MULDIV (SUPPORT_MULDIV)
    ) u_dec (
      .opcode_i        (in_opcode_i[g*32 +: 32]),
      .fault_i         (in_fault_i[g]),
      .enable_muldiv_i (enable_muldiv_i),
      .class_o         (w_cls),
      .rd_o            (w_rd),
      .rs1_o           (w_rs1),
      .rs2_o           (w_rs2)
    );

    assign w_lane_entry[g] = '{pc:     in_pc_i[g*32 +: 32],
                               opcode: in_opcode_i[g*32 +: 32],
                               cls:    w_cls,
                               rd:     w_rd,
                               rs1:    w_rs1,
                               rs2:    w_rs2};
  end

  // --------------------------------------------------------------------------
  // Pointers, level and compaction
  // --------------------------------------------------------------------------
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;

  // Slot offset of each lane within the bundle = number of valid lanes below it
  logic [CW-1:0] w_slot [LANES];
  logic [CW-1:0] w_push_cnt;

  always_comb begin
    w_push_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      w_slot[k]  = w_push_cnt;
      w_push_cnt = w_push_cnt + CW'(in_valid_i[k]);
    end
  end

  logic          w_push_en;
  logic [CW-1:0] w_pushed;
  logic [LW-1:0] w_pop_req;
  logic [LW-1:0] w_pop_eff;

  // Acceptance looks only at the registered level so it never depends on pop
  assign in_accept_o = (level_q <= LW'(DEPTH - LANES));
  assign w_push_en   = in_accept_o && !flush_i && !rst_i;
  assign w_pushed    = w_push_en ? w_push_cnt : '0;
  assign w_pop_req   = LW'(out_pop_i);
  assign w_pop_eff   = (w_pop_req > level_q) ? level_q : w_pop_req;

  assign level_d  = level_q + LW'(w_pushed) - w_pop_eff;
  assign rd_ptr_d = rd_ptr_q + PW'(w_pop_eff);
  assign wr_ptr_d = wr_ptr_q + PW'(w_pushed);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      level_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      level_q  <= level_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage (not reset; outputs are gated by level instead)
  // --------------------------------------------------------------------------
  decode_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (w_push_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (in_valid_i[k]) begin
          mem_q[wr_ptr_q + PW'(w_slot[k])] <= w_lane_entry[k];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Head window
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_out
    decode_entry_t w_head;

    assign w_head         = mem_q[rd_ptr_q + PW'(g)];
    assign out_valid_o[g] = (level_q > LW'(g));

    assign out_pc_o[g*32 +: 32]               = out_valid_o[g] ? w_head.pc     : '0;
    assign out_opcode_o[g*32 +: 32]           = out_valid_o[g] ? w_head.opcode : '0;
    assign out_class_o[g*CLASS_W +: CLASS_W]  = out_valid_o[g] ? w_head.cls    : '0;
    assign out_rd_o[g*5 +: 5]                 = out_valid_o[g] ? w_head.rd     : '0;
    assign out_rs1_o[g*5 +: 5]                = out_valid_o[g] ? w_head.rs1    : '0;
    assign out_rs2_o[g*5 +: 5]                = out_valid_o[g] ? w_head.rs2    : '0;
  end

  assign level_o = level_q;

endmodule : biriscv_decode_queue
`default_nettype wire

// File: tb/tb_biriscv_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_biriscv_decode_queue
//  Description : Self-checking bench for biriscv_decode_queue (LANES=2,
//                DEPTH=8). Directed steps followed by randomized traffic,
//                compared against a queue-based reference model whose decode
//                is a mask/match table of the recognised instruction set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_biriscv_decode_queue;

  localparam int LANES = 2;
  localparam int DEPTH = 8;

  // Instruction kinds of the reference decoder
  localparam int K_NONE = 0, K_EXEC = 1, K_JUMP = 2, K_BRANCH = 3, K_LOAD = 4,
                 K_STORE = 5, K_SYS = 6, K_CSR = 7, K_MUL = 8, K_DIV = 9;

  localparam logic [31:0] RMASK = 32'hFE00_707F;
  localparam logic [31:0] IMASK = 32'h0000_707F;

  localparam logic [31:0] POOL [18] = '{
    32'h0050_0093, 32'h0000_0013, 32'h0220_81b3, 32'h0220_d1b3, 32'h0220_e1b3,
    32'h0000_a283, 32'h0010_8023, 32'h0020_8463, 32'h0080_00ef, 32'h0000_80e7,
    32'h1234_52b7, 32'h0000_1317, 32'h3052_9073, 32'h0000_0073, 32'h0ff0_000f,
    32'h4010_d093, 32'h4020_8133, 32'h3020_0073};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    in_valid = '0;
  logic [63:0]   in_pc = '0;
  logic [63:0]   in_opcode = '0;
  logic [1:0]    in_fault = '0;
  logic          in_accept;
  logic          enable_muldiv = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    out_valid;
  logic [63:0]   out_pc;
  logic [63:0]   out_opcode;
  logic [15:0]   out_class;
  logic [9:0]    out_rd;
  logic [9:0]    out_rs1;
  logic [9:0]    out_rs2;
  logic [1:0]    out_pop = '0;
  logic [3:0]    level;

  always #5 clk = ~clk;

  biriscv_decode_queue #(
    .LANES          (LANES),
    .DEPTH          (DEPTH),
    .SUPPORT_MULDIV (1)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_pc_i         (in_pc),
    .in_opcode_i     (in_opcode),
    .in_fault_i      (in_fault),
    .in_accept_o     (in_accept),
    .enable_muldiv_i (enable_muldiv),
    .flush_i         (flush),
    .out_valid_o     (out_valid),
    .out_pc_o        (out_pc),
    .out_opcode_o    (out_opcode),
    .out_class_o     (out_class),
    .out_rd_o        (out_rd),
    .out_rs1_o       (out_rs1),
    .out_rs2_o       (out_rs2),
    .out_pop_i       (out_pop),
    .level_o         (level)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op;
    logic [7:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ent_t;

  ent_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  // ---------------------------------------------------------------- model --
  function automatic bit m(input logic [31:0] op, input logic [31:0] mask,
                           input logic [31:0] match);
    return (op & mask) == match;
  endfunction

  function automatic int ref_kind(input logic [31:0] op);
    for (int f = 0; f < 8; f++) begin
      logic [31:0] fx;
      fx = 32'(f) << 12;
      if (m(op, RMASK, 32'h33 | fx)) return K_EXEC;
      if (m(op, RMASK, 32'h0200_0033 | fx)) return (f < 4) ? K_MUL : K_DIV;
      if ((f inside {0, 2, 3, 4, 6, 7}) && m(op, IMASK, 32'h13 | fx)) return K_EXEC;
      if ((f inside {0, 1, 4, 5, 6, 7}) && m(op, IMASK, 32'h63 | fx)) return K_BRANCH;
      if ((f inside {0, 1, 2, 4, 5, 6}) && m(op, IMASK, 32'h03 | fx)) return K_LOAD;
      if ((f < 3) && m(op, IMASK, 32'h23 | fx)) return K_STORE;
      if ((f < 2) && m(op, IMASK, 32'h0F | fx)) return K_SYS;
      if ((f inside {1, 2, 3, 5, 6, 7}) && m(op, IMASK, 32'h73 | fx)) return K_CSR;
    end
    if (m(op, RMASK, 32'h4000_0033) || m(op, RMASK, 32'h4000_5033) ||
        m(op, RMASK, 32'h0000_1013) || m(op, RMASK, 32'h0000_5013) ||
        m(op, RMASK, 32'h4000_5013)) return K_EXEC;
    if (m(op, 32'h7F, 32'h37) || m(op, 32'h7F, 32'h17)) return K_EXEC;
    if (m(op, 32'h7F, 32'h6F) || m(op, IMASK, 32'h67)) return K_JUMP;
    if ((op inside {32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h1050_0073}) ||
        m(op, 32'hFE00_7FFF, 32'h1200_0073)) return K_SYS;
    return K_NONE;
  endfunction

  function automatic ent_t ref_entry(input logic [31:0] pc, input logic [31:0] op,
                                     input logic fault, input logic en);
    ent_t e;
    int   k;
    bit   wr;
    e     = '0;
    e.pc  = pc;
    e.op  = op;
    e.rd  = op[11:7];
    e.rs1 = op[19:15];
    e.rs2 = op[24:20];
    k     = fault ? K_NONE : ref_kind(op);
    if ((k == K_MUL || k == K_DIV) && !en) k = K_NONE;
    wr = 1'b0;
    case (k)
      K_EXEC:   begin e.cls = 8'h02; wr = 1'b1; end
      K_JUMP:   begin e.cls = 8'h08; wr = 1'b1; end
      K_BRANCH: e.cls = 8'h08;
      K_LOAD:   begin e.cls = 8'h04; wr = 1'b1; end
      K_STORE:  e.cls = 8'h04;
      K_SYS:    e.cls = 8'h40;
      K_CSR:    begin e.cls = 8'h40; wr = 1'b1; end
      K_MUL:    begin e.cls = 8'h10; wr = 1'b1; end
      K_DIV:    begin e.cls = 8'h20; wr = 1'b1; end
      default:  e.cls = 8'hC0;
    endcase
    if (wr && (op[11:7] != 5'd0)) e.cls[0] = 1'b1;
    return e;
  endfunction

  task automatic model_step();
    bit acc;
    int p;
    if (rst || flush) begin
      mq.delete();
    end else begin
      acc = (DEPTH - mq.size()) >= LANES;
      p   = (int'(out_pop) > mq.size()) ? mq.size() : int'(out_pop);
      repeat (p) void'(mq.pop_front());
      if (acc) begin
        for (int k = 0; k < LANES; k++) begin
          if (in_valid[k]) begin
            mq.push_back(ref_entry(in_pc[k*32 +: 32], in_opcode[k*32 +: 32],
                                   in_fault[k], enable_muldiv));
          end
        end
      end
    end
  endtask

  // -------------------------------------------------------------- checking --
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t e;
    chk("level", 32'(level), 32'(mq.size()));
    chk("accept", 32'(in_accept), 32'((DEPTH - mq.size()) >= LANES));
    for (int k = 0; k < LANES; k++) begin
      e = (k < mq.size()) ? mq[k] : '0;
      chk($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(k < mq.size()));
      chk($sformatf("pc%0d", k),    out_pc[k*32 +: 32],       e.pc);
      chk($sformatf("op%0d", k),    out_opcode[k*32 +: 32],   e.op);
      chk($sformatf("class%0d", k), 32'(out_class[k*8 +: 8]), 32'(e.cls));
      chk($sformatf("rd%0d", k),    32'(out_rd[k*5 +: 5]),    32'(e.rd));
      chk($sformatf("rs1_%0d", k),  32'(out_rs1[k*5 +: 5]),   32'(e.rs1));
      chk($sformatf("rs2_%0d", k),  32'(out_rs2[k*5 +: 5]),   32'(e.rs2));
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare 1 time unit later.
  task automatic cycle(input logic [1:0] v, input logic [31:0] op0, input logic [31:0] op1,
                       input logic [1:0] f, input int pop, input logic fl,
                       input logic en, input logic rs);
    @(negedge clk);
    in_valid      = v;
    in_opcode     = {op1, op0};
    in_pc         = {pc_ctr + 32'd4, pc_ctr};
    pc_ctr        = pc_ctr + 32'd8;
    in_fault      = f;
    out_pop       = 2'(pop);
    flush         = fl;
    enable_muldiv = en;
    rst           = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  function automatic logic [31:0] gen_op();
    logic [31:0] op;
    if ($urandom_range(0, 7) == 0) return $urandom;
    op = POOL[$urandom_range(0, 17)];
    if ($urandom_range(0, 1) == 1) begin
      op[11:7]  = 5'($urandom);
      op[19:15] = 5'($urandom);
      op[24:20] = 5'($urandom);
    end
    return op;
  endfunction

  // --------------------------------------------------------------- stimulus --
  initial begin
    // Reset, then one idle cycle
    cycle(2'b00, 32'h0, 32'h0, 2'b00, 0, 1'b0, 1'b0, 1'b1);
    cycle(2'b00, 32'h0, 32'h0, 2'b00, 0, 1'b0, 1'b0, 1'b1);
    cycle(2'b00, 32'h0, 32'h0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_accept", 32'(in_accept), 32'd1);
    chk("rst_data", out_pc | out_opcode[31:0] | 32'(out_class), 32'd0);

    // ADDI x1,x0,5 + NOP
    cycle(2'b11, 32'h0050_0093, 32'h0000_0013, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    chk("addi_valid", 32'(out_valid), 32'd3);
    chk("addi_class", 32'(out_class[7:0]), 32'h03);
    chk("addi_rd", 32'(out_rd[4:0]), 32'd1);
    chk("nop_class", 32'(out_class[15:8]), 32'h02);

    // MUL with M disabled, then enabled
    cycle(2'b01, 32'h0220_81b3, 32'h0, 2'b00, 2, 1'b0, 1'b0, 1'b0);
    chk("mul_off_class", 32'(out_class[7:0]), 32'hC0);
    cycle(2'b01, 32'h0220_81b3, 32'h0, 2'b00, 1, 1'b0, 1'b1, 1'b0);
    chk("mul_on_class", 32'(out_class[7:0]), 32'h11);

    // Hole in lane 0: LW x5,0(x1) in lane 1 lands at head lane 0
    cycle(2'b10, 32'h0, 32'h0000_a283, 2'b00, 1, 1'b0, 1'b0, 1'b0);
    chk("lw_valid", 32'(out_valid), 32'd1);
    chk("lw_class", 32'(out_class[7:0]), 32'h05);
    chk("lw_rd", 32'(out_rd[4:0]), 32'd5);

    // Fill to 7, then a rejected push
    for (int i = 0; i < 4; i++)
      cycle(2'b11, gen_op(), gen_op(), 2'b00, 0, 1'b0, 1'b1, 1'b0);
    chk("full_level", 32'(level), 32'd7);
    chk("full_accept", 32'(in_accept), 32'd0);

    // Pop while full: push still refused this cycle
    cycle(2'b11, gen_op(), gen_op(), 2'b00, 2, 1'b0, 1'b1, 1'b0);
    chk("full_pop_level", 32'(level), 32'd5);
    cycle(2'b01, gen_op(), gen_op(), 2'b00, 0, 1'b0, 1'b1, 1'b0);

    // Steady state: pop 2 / push 2 across pointer wrap
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, gen_op(), gen_op(), 2'b00, 2, 1'b0, 1'b1, 1'b0);
      chk("steady_level", 32'(level), 32'd6);
    end

    // BEQ + ECALL, then flush with a pop and a valid push
    cycle(2'b11, 32'h0020_8463, 32'h0000_0073, 2'b00, 2, 1'b0, 1'b1, 1'b0);
    cycle(2'b11, gen_op(), gen_op(), 2'b00, 2, 1'b1, 1'b1, 1'b0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with occasional faults, flushes and resets
    for (int i = 0; i < 500; i++) begin
      cycle(2'($urandom), gen_op(), gen_op(),
            {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)},
            $urandom_range(0, 2), ($urandom_range(0, 39) == 0),
            1'($urandom), ($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_biriscv_decode_queue
`default_nettype wire
